// File: rtl/sc_display_scan_if.sv
// rtl/sc_display_scan_if.sv - CPU output ports in, BCD display digits out; ovf exists only with SC_DISP_OVF_EN
interface sc_display_scan_if;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic        freeze;
  logic [3:0]  dig0;
  logic [3:0]  dig1;
  logic [3:0]  dig2;
  logic [3:0]  dig3;
  logic [3:0]  dig4;
  logic [3:0]  dig5;
  logic        busy;
  logic        update;
`ifdef SC_DISP_OVF_EN
  logic [2:0]  ovf;

  modport master (
    output out_port0, out_port1, out_port2, freeze,
    input  dig0, dig1, dig2, dig3, dig4, dig5, busy, update, ovf
  );
  modport slave (
    input  out_port0, out_port1, out_port2, freeze,
    output dig0, dig1, dig2, dig3, dig4, dig5, busy, update, ovf
  );
`else
  modport master (
    output out_port0, out_port1, out_port2, freeze,
    input  dig0, dig1, dig2, dig3, dig4, dig5, busy, update
  );
  modport slave (
    input  out_port0, out_port1, out_port2, freeze,
    output dig0, dig1, dig2, dig3, dig4, dig5, busy, update
  );
`endif
endinterface

// File: rtl/sc_display_scan.sv
// rtl/sc_display_scan.sv - three 32-bit ports to six BCD digits via one shared divide-by-10, atomic commit
// SC_DISP_OVF_EN: values >= 100 blank to F/F and raise ovf instead of saturating to 99.
module sc_display_scan #(
  parameter int REFRESH = 1000
) (
  input  logic              clock,
  input  logic              resetn,
  sc_display_scan_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_STORE, S_COMMIT} state_t;

  localparam logic [19:0] RELOAD = 20'(REFRESH - 1);

  state_t          state, state_nx;
  logic [19:0]     cnt;
  logic [1:0]      idx;
  logic [6:0]      work;
  logic [3:0]      tens;
  logic [5:0][3:0] stg;
  logic [5:0][3:0] dig_q;
  logic            update_q;
  logic [31:0]     port_val;
  logic            port_big;
`ifdef SC_DISP_OVF_EN
  logic            ovf_flag;
  logic [2:0]      stg_ovf;
  logic [2:0]      ovf_q;
`endif

  // Full 32-bit compare so values with bit 31 set count as large.
  always_comb begin
    case (idx)
      2'd0:    port_val = bus.out_port0;
      2'd1:    port_val = bus.out_port1;
      default: port_val = bus.out_port2;
    endcase
    port_big = (port_val >= 32'd100);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cnt == '0) state_nx = S_LOAD;
`ifdef SC_DISP_OVF_EN
      S_LOAD:   state_nx = port_big ? S_STORE : S_SUB;
`else
      S_LOAD:   state_nx = S_SUB;
`endif
      S_SUB:    if (work < 7'd10) state_nx = S_STORE;
      S_STORE:  state_nx = (idx == 2'd2) ? S_COMMIT : S_LOAD;
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != S_IDLE);
    bus.update = update_q;
    bus.dig0   = dig_q[0];
    bus.dig1   = dig_q[1];
    bus.dig2   = dig_q[2];
    bus.dig3   = dig_q[3];
    bus.dig4   = dig_q[4];
    bus.dig5   = dig_q[5];
`ifdef SC_DISP_OVF_EN
    bus.ovf    = ovf_q;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt      <= RELOAD;
      idx      <= 2'd0;
      work     <= '0;
      tens     <= '0;
      stg      <= '0;
      dig_q    <= '0;
      update_q <= 1'b0;
`ifdef SC_DISP_OVF_EN
      ovf_flag <= 1'b0;
      stg_ovf  <= '0;
      ovf_q    <= '0;
`endif
    end else begin
      update_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt == '0) begin
            cnt <= RELOAD;
            idx <= 2'd0;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        S_LOAD: begin
`ifdef SC_DISP_OVF_EN
          ovf_flag <= port_big;
          work     <= port_big ? 7'd15 : port_val[6:0];
          tens     <= port_big ? 4'hF : 4'd0;
`else
          work     <= port_big ? 7'd99 : port_val[6:0];
          tens     <= 4'd0;
`endif
        end
        S_SUB: begin
          if (work >= 7'd10) begin
            work <= work - 7'd10;
            tens <= tens + 4'd1;
          end
        end
        S_STORE: begin
          stg[{idx, 1'b0}] <= tens;
          stg[{idx, 1'b1}] <= work[3:0];
`ifdef SC_DISP_OVF_EN
          stg_ovf[idx]     <= ovf_flag;
`endif
          if (idx != 2'd2) idx <= idx + 2'd1;
        end
        S_COMMIT: begin
          // A frozen round is simply dropped; staging is cleared either way.
          if (!bus.freeze) begin
            dig_q    <= stg;
            update_q <= 1'b1;
`ifdef SC_DISP_OVF_EN
            ovf_q    <= stg_ovf;
`endif
          end
          stg <= '0;
`ifdef SC_DISP_OVF_EN
          stg_ovf <= '0;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_display_scan.sv
// tb/tb_sc_display_scan.sv - bench for sc_display_scan: vector table, scoreboard, reset/freeze/atomic sequences
module tb_sc_display_scan;
  localparam int REFRESH = 4;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  sc_display_scan_if bus ();

  sc_display_scan #(.REFRESH(REFRESH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] p0, p1, p2;
    logic [23:0] dig_off;
    int          busy_off;
    logic [23:0] dig_on;
    logic [2:0]  ovf_on;
    int          busy_on;
  } vec_t;

  typedef struct packed {
    logic [23:0] dig;
    logic [2:0]  ovf;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[8];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] shown;
  logic [23:0] dut_dig;
  logic [2:0]  dut_ovf;

  assign dut_dig = {bus.dig0, bus.dig1, bus.dig2, bus.dig3, bus.dig4, bus.dig5};
`ifdef SC_DISP_OVF_EN
  assign dut_ovf = bus.ovf;
`else
  assign dut_ovf = 3'b000;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_round(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                           input logic [23:0] edig, input logic [2:0] eovf, input int ebusy,
                           input bit frz, input int mid_cyc, input logic [31:0] mid_val,
                           input string name);
    int   n;
    int   w;
    int   bad;
    bit   seen;
    exp_t e;
    bus.out_port0 = p0;
    bus.out_port1 = p1;
    bus.out_port2 = p2;
    bus.freeze    = 1'b0;
    e.dig = edig;
    e.ovf = eovf;
    if (!frz) sbq.push_back(e);
    w = 0;
    while (!bus.busy && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!bus.busy) begin
      chk({name, " start"}, 64'(bus.busy), 64'd1);
      if (!frz) void'(sbq.pop_back());
      return;
    end
    n   = 0;
    bad = 0;
    while (bus.busy && n < 60) begin
      n++;
      if (dut_dig !== shown) bad++;
      if (n == mid_cyc) bus.out_port0 = mid_val;
      if (frz && n == ebusy) bus.freeze = 1'b1;
      @(negedge clock);
      bus.freeze = 1'b0;
    end
    chk({name, " busy_cycles"}, 64'(n), 64'(ebusy));
    chk({name, " stable"}, 64'(bad), 64'd0);
    if (frz) begin
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (bus.update) seen = 1'b1;
        @(negedge clock);
      end
      chk({name, " no_update"}, 64'(seen), 64'd0);
      chk({name, " held"}, 64'(dut_dig), 64'(shown));
    end else begin
      chk({name, " update"}, 64'(bus.update), 64'd1);
      e = sbq.pop_front();
      chk({name, " dig"}, 64'(dut_dig), 64'(e.dig));
`ifdef SC_DISP_OVF_EN
      chk({name, " ovf"}, 64'(dut_ovf), 64'(e.ovf));
`endif
      shown = e.dig;
      @(negedge clock);
      chk({name, " update_width"}, 64'(bus.update), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{32'd7,   32'd42,  32'd99,         24'h074299, 23, 24'h074299, 3'b000, 23};
    tbl[1] = '{32'd0,   32'd0,   32'd0,          24'h000000, 10, 24'h000000, 3'b000, 10};
    tbl[2] = '{32'd90,  32'd95,  32'd99,         24'h909599, 37, 24'h909599, 3'b000, 37};
    tbl[3] = '{32'd100, 32'd5,   32'hFFFF_FFFF,  24'h990599, 28, 24'hFF05FF, 3'b101, 8};
    tbl[4] = '{32'd13,  32'd250, 32'h8000_0000,  24'h139999, 29, 24'h13FFFF, 3'b110, 9};
    tbl[5] = '{32'd0,   32'd5,   32'd0,          24'h000500, 10, 24'h000500, 3'b000, 10};
    tbl[6] = '{32'd10,  32'd9,   32'd50,         24'h100950, 16, 24'h100950, 3'b000, 16};
    tbl[7] = '{32'd3,   32'd6,   32'd8,          24'h030608, 10, 24'h030608, 3'b000, 10};

    resetn        = 1'b0;
    bus.out_port0 = '0;
    bus.out_port1 = '0;
    bus.out_port2 = '0;
    bus.freeze    = 1'b0;
    shown         = '0;
    repeat (3) @(negedge clock);
    chk("reset dig", 64'(dut_dig), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset update", 64'(bus.update), 64'd0);
    chk("reset ovf", 64'(dut_ovf), 64'd0);

    resetn = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("first load latency", 64'(n), 64'(REFRESH));
    n = 0;
    while (bus.busy && n < 60) begin
      @(negedge clock);
      n++;
    end

    for (int i = 0; i < 8; i++) begin
`ifdef SC_DISP_OVF_EN
      run_round(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].dig_on, tbl[i].ovf_on, tbl[i].busy_on,
                1'b0, 0, 32'd0, $sformatf("vec%0d", i));
`else
      run_round(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].dig_off, 3'b000, tbl[i].busy_off,
                1'b0, 0, 32'd0, $sformatf("vec%0d", i));
`endif
    end

    run_round(32'd1, 32'd2, 32'd3, 24'h010203, 3'b000, 10, 1'b1, 0, 32'd0, "freeze");
    run_round(32'd1, 32'd2, 32'd3, 24'h010203, 3'b000, 10, 1'b0, 0, 32'd0, "unfreeze");

    run_round(32'd7,  32'd42, 32'd99, 24'h074299, 3'b000, 23, 1'b0, 0, 32'd0,  "atomic_pre");
    run_round(32'd7,  32'd42, 32'd99, 24'h074299, 3'b000, 23, 1'b0, 5, 32'd13, "atomic_mid");
    run_round(32'd13, 32'd42, 32'd99, 24'h134299, 3'b000, 24, 1'b0, 0, 32'd0,  "atomic_next");

    bus.out_port0 = 32'd57;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midsub reset dig", 64'(dut_dig), 64'd0);
    chk("midsub reset busy", 64'(bus.busy), 64'd0);
    chk("midsub reset update", 64'(bus.update), 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("midsub reload latency", 64'(n), 64'(REFRESH));
    chk("scoreboard drained", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_display_scan.md
# sc_display_scan

Sequencer that converts the three 32-bit CPU output ports into six BCD digits for the board's seven-segment displays. One shared iterative divide-by-10 unit serves the ports in fixed order 0, 1, 2. All six digits then commit together, so the displays never show a half-updated value. It sits between the CPU's output port registers and the `sevenseg` decoder instances.

## Interface

Parameters:
- `REFRESH`, default 1000: idle cycles between conversion rounds; legal range 1 to 2^20.

Ports:
- `clock`, input, 1: system clock; all state changes on the rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `out_port0`, `out_port1`, `out_port2`, input, 32 each: unsigned values to display.
- `freeze`, input, 1: when high, suppresses the commit of the round that is finishing.
- `dig0` … `dig5`, output, 4 each: BCD digits.
  - `dig0`/`dig1` = port0 tens/ones.
  - `dig2`/`dig3` = port1 tens/ones.
  - `dig4`/`dig5` = port2 tens/ones.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `update`, output, 1: single-cycle pulse in the cycle after a commit.
- `ovf`, output, 3: exists only with `SC_DISP_OVF_EN`; bit i flags port i out of range.

## Operation

State machine has five states: IDLE, LOAD, SUB, STORE, COMMIT.

- **IDLE**
  - A refresh counter decrements each cycle.
  - When it reaches 0, it reloads to `REFRESH-1`, sets idx=0 and goes to LOAD.
  - The counter holds its value outside IDLE.
- **LOAD**
  - Samples `out_port[idx]` into `work` (7 bits after range handling) and clears `tens`; goes to SUB.
  - Ports are sampled only here. A port changing mid-round affects only ports not yet loaded.
- **SUB**
  - If `work` ≥ 10: `work` -= 10, `tens` += 1, stay in SUB.
  - Otherwise go to STORE.
- **STORE**
  - Writes `tens`/`work` into the staging pair for idx.
  - If idx=2 go to COMMIT; otherwise idx+1 and go to LOAD.
- **COMMIT**
  - If `freeze`=0: all six staging digits copy to `dig*` simultaneously, and `update` pulses on the next cycle.
  - If `freeze`=1: staging is discarded, `dig*` are unchanged and there is no `update` pulse.
  - Either way, go to IDLE.

Range handling, without the macro:
- Values ≥ 100 saturate to 99.
- The full 32-bit input is compared, so 0x8000_0000 is treated as large, not negative.

Reset (asynchronous, `resetn`=0):
- State → IDLE, idx=0, refresh counter → `REFRESH-1`.
- All `dig*` = 0, staging = 0, `busy`=0, `update`=0, `ovf`=0.
- Reset in the middle of a round aborts it with no partial commit.

## Timing

- Per-port conversion takes 3 + `tens` cycles (LOAD + (`tens`+1) SUB + STORE); the worst case is 12.
- A round is LOAD…COMMIT, 3×(3+tens) + 1 cycles.
  - Minimum: 10 cycles (all values < 10).
  - Maximum: 37 cycles (all values ≥ 90).
- First LOAD occurs `REFRESH` cycles after `resetn` deasserts.
- Period between LOAD starts = `REFRESH` + round length.
- `dig*` change on the clock edge leaving COMMIT. `update` is high for exactly the following cycle, which is IDLE.
- `busy` rises on the edge entering LOAD and falls on the edge entering IDLE.
- `freeze` is sampled only in COMMIT; its level in other cycles is ignored.
- With `REFRESH`=1, IDLE lasts exactly one cycle between rounds.

## Configuration

`SC_DISP_OVF_EN` is a preprocessor macro.

- **Defined:**
  - The `ovf[2:0]` port exists.
  - A port value ≥ 100 stores tens=ones=4'hF (the decoder blanks it), skips SUB (LOAD→STORE directly, 2 cycles), and sets staging ovf[idx].
  - `ovf` commits together with the digits, follows the same `freeze` rule, and resets to 0.
- **Undefined:**
  - There is no `ovf` port.
  - Values ≥ 100 saturate to 99 as described in Operation.

## Test plan

- **Reset check:** `resetn`=0 mid-SUB with port0=57 → all `dig*`=0, `busy`=0, `update`=0 immediately, with no clock required. After release with `REFRESH`=4, first LOAD occurs 4 cycles later.
- **Basic round:** `REFRESH`=4, ports 7, 42, 99.
  - Result: `dig`=0,7,4,2,9,9.
  - `busy` high for 3+7+12+1 = 23 cycles.
  - One `update` pulse, the cycle after the commit.
- **Atomic commit:** change port0 from 7 to 13 while port1 is in SUB. `dig0`/`dig1` stay 0/7 until the next round, then show 1/3; `dig2`…`dig5` never show intermediate values.
- **Freeze:** `freeze`=1 only during COMMIT of a round with ports 1, 2, 3 → `dig*` unchanged and no `update`. The next round with `freeze`=0 → 0,1,0,2,0,3 plus an `update` pulse.
- **Range, macro off:** port2=100 → `dig4`/`dig5`=9/9. Port2=0xFFFF_FFFF → 9/9.
- **Range, macro on:** port1=250 → `dig2`/`dig3`=F/F, `ovf`=3'b010, port1 conversion takes 2 cycles. Next round with port1=5 → 0/5, `ovf`=0.
